// File: rtl/convex_pkg.sv
// Shared types and constants for the CONVEX point path.
package convex_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned NIB_W   = 5;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } px_t;

    // Serializer count values selecting each nibble of a point.
    localparam logic [2:0] NIB_X_HI = 3'd4;
    localparam logic [2:0] NIB_X_LO = 3'd3;
    localparam logic [2:0] NIB_Y_HI = 3'd2;
    localparam logic [2:0] NIB_Y_LO = 3'd1;
    localparam logic [2:0] NIB_IDLE = 3'd0;

endpackage

// File: rtl/convex_pt_fifo.sv
// Synchronous point FIFO with level output; no write-to-read bypass.
module convex_pt_fifo
    import convex_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  px_t                      wdata,
    input  logic                     pop,
    output px_t                      rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    px_t           mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          do_push;
    logic          do_pop;

    // Full/empty come from the registered level, so a same-cycle pop never frees a push slot.
    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];
    assign level   = level_q;

    // Pointer and level bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage write; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/convex_pt_feeder.sv
// Buffers (X,Y) points and serializes one per CONVEX request as four 5-bit nibbles.
module convex_pt_feeder
    import convex_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [COORD_W-1:0]     in_x,
    input  logic [COORD_W-1:0]     in_y,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   read_pt,
    output logic [NIB_W-1:0]       pt_xy,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_lvl,
    output logic [7:0]             pt_cnt
);

    px_t        head;
    px_t        hold_q;
    logic [2:0] cnt_q;
    logic [7:0] pt_cnt_q;
    logic       full;
    logic       empty;
    logic       start;

    convex_pt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .wdata ('{x: in_x, y: in_y}),
        .pop   (start),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_lvl)
    );

    // A new point may start while the last nibble is on the bus, giving gap-free delivery.
    assign start    = (cnt_q <= NIB_Y_LO) && read_pt && !empty;
    assign in_ready = !full;
    assign busy     = (cnt_q != NIB_IDLE);
    assign pt_cnt   = pt_cnt_q;

    // Serializer countdown, hold register and delivered-point counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= NIB_IDLE;
            hold_q   <= '0;
            pt_cnt_q <= '0;
        end else if (start) begin
            cnt_q    <= NIB_X_HI;
            hold_q   <= head;
            pt_cnt_q <= pt_cnt_q + 8'd1;
        end else if (cnt_q > NIB_Y_LO) begin
            cnt_q    <= cnt_q - 3'd1;
        end else begin
            cnt_q    <= NIB_IDLE;
        end
    end

    // Nibble select decoded purely from registers.
    always_comb begin
        pt_xy = '0;
        case (cnt_q)
            NIB_X_HI: pt_xy = hold_q.x[9:5];
            NIB_X_LO: pt_xy = hold_q.x[4:0];
            NIB_Y_HI: pt_xy = hold_q.y[9:5];
            NIB_Y_LO: pt_xy = hold_q.y[4:0];
            default:  pt_xy = '0;
        endcase
    end

endmodule

// File: tb/tb_convex_pt_feeder.sv
// Self-checking bench for convex_pt_feeder against a queue-based reference model.
module tb_convex_pt_feeder;
    import convex_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] in_x;
    logic [9:0] in_y;
    logic       in_valid;
    logic       in_ready;
    logic       read_pt;
    logic [4:0] pt_xy;
    logic       busy;
    logic [4:0] fifo_lvl;
    logic [7:0] pt_cnt;

    convex_pt_feeder #(
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .read_pt  (read_pt),
        .pt_xy    (pt_xy),
        .busy     (busy),
        .fifo_lvl (fifo_lvl),
        .pt_cnt   (pt_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: buffered points, nibbles still to appear on the bus, delivery count.
    px_t        fifoq [$];
    logic [4:0] serq  [$];
    logic [7:0] ptc;
    int         delivered;
    int         errs   = 0;
    int         checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Apply inputs, advance one edge, update the model, then compare every output.
    task automatic step(input logic r, input logic v, input logic [9:0] x, input logic [9:0] y,
                        input logic rd);
        px_t p;
        bit  can_push;
        rst_n    = r;
        in_valid = v;
        in_x     = x;
        in_y     = y;
        read_pt  = rd;
        @(posedge clk);
        if (!r) begin
            fifoq.delete();
            serq.delete();
            ptc = 8'd0;
        end else begin
            can_push = (fifoq.size() < DEPTH);
            if (serq.size() <= 1 && rd && fifoq.size() > 0) begin
                p = fifoq.pop_front();
                serq.delete();
                serq.push_back(p.x[9:5]);
                serq.push_back(p.x[4:0]);
                serq.push_back(p.y[9:5]);
                serq.push_back(p.y[4:0]);
                ptc = ptc + 8'd1;
                delivered++;
            end else if (serq.size() > 0) begin
                void'(serq.pop_front());
            end
            if (v && can_push) fifoq.push_back('{x: x, y: y});
        end
        #1;
        chk("pt_xy", 32'(pt_xy), 32'(serq.size() != 0 ? serq[0] : 5'd0));
        chk("busy", 32'(busy), 32'(serq.size() != 0));
        chk("fifo_lvl", 32'(fifo_lvl), 32'(fifoq.size()));
        chk("pt_cnt", 32'(pt_cnt), 32'(ptc));
        chk("in_ready", 32'(in_ready), 32'(fifoq.size() < DEPTH));
    endtask

    task automatic idle(input logic rd);
        step(1'b1, 1'b0, 10'd0, 10'd0, rd);
    endtask

    initial begin
        ptc       = 8'd0;
        delivered = 0;

        // Reset state
        step(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        step(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        chk("rst_xy", 32'(pt_xy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_lvl", 32'(fifo_lvl), 32'd0);

        // Single point (1000,37): 31, 8, 1, 5 then idle
        step(1'b1, 1'b1, 10'd1000, 10'd37, 1'b0);
        idle(1'b1); chk("t1_n0", 32'(pt_xy), 32'd31);
        idle(1'b1); chk("t1_n1", 32'(pt_xy), 32'd8);
        idle(1'b1); chk("t1_n2", 32'(pt_xy), 32'd1);
        idle(1'b1); chk("t1_n3", 32'(pt_xy), 32'd5);
        idle(1'b1); chk("t1_end", 32'(pt_xy), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_cnt", 32'(pt_cnt), 32'd1);

        // Back-to-back (0,1023) and (512,31)
        step(1'b1, 1'b1, 10'd0, 10'd1023, 1'b1);
        step(1'b1, 1'b1, 10'd512, 10'd31, 1'b1); chk("t2_n0", 32'(pt_xy), 32'd0);
        idle(1'b1); chk("t2_n1", 32'(pt_xy), 32'd0);
        idle(1'b1); chk("t2_n2", 32'(pt_xy), 32'd31);
        idle(1'b1); chk("t2_n3", 32'(pt_xy), 32'd31);
        idle(1'b1); chk("t2_n4", 32'(pt_xy), 32'd16);
        idle(1'b1); chk("t2_n5", 32'(pt_xy), 32'd0);
        idle(1'b1); chk("t2_n6", 32'(pt_xy), 32'd0);
        idle(1'b1); chk("t2_n7", 32'(pt_xy), 32'd31);
        idle(1'b0); chk("t2_cnt", 32'(pt_cnt), 32'd3);

        // Request while empty, data arrives later
        idle(1'b1);
        idle(1'b1);
        idle(1'b1); chk("t3_wait", 32'(busy), 32'd0);
        step(1'b1, 1'b1, 10'd5, 10'd6, 1'b1); chk("t3_push", 32'(busy), 32'd0);
        idle(1'b1); chk("t3_n0", 32'(pt_xy), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        idle(1'b1); chk("t3_n1", 32'(pt_xy), 32'd5);
        idle(1'b1); chk("t3_n2", 32'(pt_xy), 32'd0);
        idle(1'b0); chk("t3_n3", 32'(pt_xy), 32'd6);
        idle(1'b0);

        // Fill to full, 17th offer rejected, one start frees a slot
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 10'(i * 37), 10'(1023 - i), 1'b0);
        chk("t4_ready", 32'(in_ready), 32'd0);
        chk("t4_lvl", 32'(fifo_lvl), 32'd16);
        step(1'b1, 1'b1, 10'd999, 10'd999, 1'b0);
        chk("t4_reject", 32'(fifo_lvl), 32'd16);
        idle(1'b1);
        chk("t4_free", 32'(in_ready), 32'd1);
        chk("t4_lvl2", 32'(fifo_lvl), 32'd15);

        // Reset mid-transfer with 3 queued
        step(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 10'(100 + i), 10'(200 + i), 1'b0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        chk("t5_mid", 32'(pt_xy), 32'(10'(202) >> 5));
        step(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        chk("t5_xy", 32'(pt_xy), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_lvl", 32'(fifo_lvl), 32'd0);
        chk("t5_cnt", 32'(pt_cnt), 32'd0);
        chk("t5_ready", 32'(in_ready), 32'd1);

        // Randomized traffic past the 8-bit count wrap
        delivered = 0;
        for (int i = 0; i < 6000 && delivered < 260; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end
        chk("t6_delivered", 32'(delivered >= 260), 32'd1);
        chk("t6_wrap", 32'(pt_cnt), 32'(delivered % 256));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
